ctrl_smp_seq: RTL
=================

Name: ctrl_smp_seq

Overview:
- Sample sequencer for the SRC register-file path; generates every per-cycle control word consumed by the register-file address driver: en_init, en_load, new_smp, out_smp, result_reg, error_reg.
- Accepts asynchronous-rate input-sample strobes and output-sample requests, arbitrates between them, then runs either a ring-buffer shift (INIT) or a multiply-accumulate sweep (LOAD).
- Sits between the rate/phase generator and the register-file driver.

Parameters:
WIDTH, 3, register-file address width
NREG, 8, ring-buffer depth in registers; legal range 2..2**WIDTH

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
smp_valid  in  1  one-cycle strobe: new input sample available
out_req  in  1  one-cycle strobe: output sample requested
en_init  out  1  ring-shift phase active
en_load  out  1  accumulate phase active
new_smp  out  1  final INIT step; write new sample to address 0
out_smp  out  1  final LOAD step; output sample complete
result_reg  out  WIDTH  result register address for the current step
error_reg  out  WIDTH  error register address for the current step
busy  out  1  state != IDLE
done  out  1  one-cycle pulse in the cycle after the final LOAD step
overrun  out  1  sticky; a strobe arrived while its pending flag was already set

Behaviour:
- All outputs are registered on posedge. Downstream samples them on negedge, so they must settle within half a cycle.
- Reset (rst=1 at posedge, including mid-sequence):
  - state=IDLE, step counter=0, both pending flags=0, overrun=0.
  - All outputs 0 from the following cycle.
  - No partial sequence resumes after reset is released.
- Pending flags:
  - smp_valid sets pend_smp; out_req sets pend_out. Both can be set in the same cycle.
  - A flag clears in the cycle its sequence is launched.
  - A strobe arriving while its flag is already 1 sets overrun. The strobe is dropped; the flag stays 1.
  - A strobe arriving in the same cycle its flag is cleared by a launch re-arms the flag. This is not an overrun.
- FSM states:
  - IDLE: if pend_smp (or smp_valid this cycle), go to INIT; otherwise, if pend_out (or out_req this cycle), go to LOAD.
  - Input samples have strict priority; an output request waits until INIT finishes.
  - INIT: runs NREG cycles, step k=0..NREG-1.
    - en_init=1, en_load=0.
    - For k<NREG-1: result_reg=NREG-1-k, new_smp=0.
    - For k=NREG-1: result_reg=0, new_smp=1.
    - error_reg=NREG-1-k throughout.
  - LOAD: runs NREG cycles, step k=0..NREG-1.
    - en_load=1, en_init=0, result_reg=k, error_reg=k.
    - out_smp=1 only at k=NREG-1.
  - After the final step of either state: if a pending flag is set, enter the next sequence with zero idle cycles (same priority rule); otherwise go to IDLE.
  - done pulses in the first cycle after the final LOAD step, whether the next state is IDLE or another sequence.
- In IDLE: en_init, en_load, new_smp and out_smp are 0; result_reg and error_reg hold 0.
- en_init and en_load are never both 1.
- The step counter is WIDTH+1 bits wide, so NREG=2**WIDTH terminates cleanly. Addresses are the counter truncated to WIDTH bits.
- Latency: a strobe arriving in IDLE gives the first active control word in the next cycle.
  - INIT spans NREG cycles; LOAD spans NREG cycles.
  - A full output with no contention takes 1+NREG cycles to the out_smp cycle and 2+NREG cycles to the done cycle.

Decomposition:
- Shared package ctrl_pkg holds:
  - the state encoding localparams ST_IDLE, ST_INIT, ST_LOAD (2-bit);
  - the default ring depth constant, shared with ctrl_regfdrv instances.
- One natural sub-module, ctrl_step_cnt: a loadable down/up step counter with a terminal-count flag. It is reused for both phases through a direction input.
- Arbitration and the FSM stay in the top module.

Test Plan (all with NREG=8, WIDTH=3):
- Reset, then smp_valid pulse in IDLE -> 8 cycles of en_init=1 with result_reg 7,6,5,4,3,2,1,0. new_smp=1 only on the 8th cycle. Then busy=0.
- out_req pulse in IDLE -> 8 cycles of en_load=1 with result_reg=error_reg 0..7. out_smp=1 on the 8th cycle; done=1 on the next cycle.
- smp_valid and out_req in the same cycle -> INIT 8 cycles, then LOAD 8 cycles back-to-back with no gap. done only after LOAD. overrun=0.
- Two smp_valid strobes during LOAD, 2 cycles apart -> first sets pend_smp, second sets overrun=1 (sticky). A single INIT follows LOAD.
- rst=1 at LOAD step 4 -> next cycle all outputs 0, state IDLE, overrun=0, pending cleared. No done pulse.
- smp_valid strobe exactly on the final INIT step (pend_smp being cleared) -> a second INIT starts immediately. overrun stays 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the sample sequencer and the register-file driver:
// state encoding and the default ring-buffer geometry.
package ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  localparam int DEFAULT_WIDTH = 3;
  localparam int DEFAULT_NREG  = 8;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_INIT = ST_INIT,
    S_LOAD = ST_LOAD
  } state_t;

endpackage

// File: rtl/ctrl_step_cnt.sv
// Loadable step counter shared by both phases: counts down for the ring shift,
// up for the accumulate sweep, and flags the terminal step of each.
module ctrl_step_cnt
  import ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREG  = DEFAULT_NREG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH:0]   load_val,
  input  logic             dir_up,
  input  logic             en,
  output logic [WIDTH:0]   cnt_nxt,
  output logic             tc
);

  localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(NREG - 1);

  logic [WIDTH:0] cnt;

  // Next value is exported so the owner can register outputs decoded from it.
  always_comb begin
    cnt_nxt = cnt;
    if (load) begin
      cnt_nxt = load_val;
    end else if (en) begin
      cnt_nxt = dir_up ? cnt + 1'b1 : cnt - 1'b1;
    end
  end

  assign tc = dir_up ? (cnt == LAST) : (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/ctrl_smp_seq.sv
// Sample sequencer: arbitrates input-sample strobes against output requests and
// emits the per-cycle register-file control word for ring shift or MAC sweep.
module ctrl_smp_seq
  import ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREG  = DEFAULT_NREG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             smp_valid,
  input  logic             out_req,
  output logic             en_init,
  output logic             en_load,
  output logic             new_smp,
  output logic             out_smp,
  output logic [WIDTH-1:0] result_reg,
  output logic [WIDTH-1:0] error_reg,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(NREG - 1);

  state_t         state, state_n;
  logic           pend_smp, pend_out;
  logic           launch_smp, launch_out;
  logic           load, cnt_en, tc;
  logic [WIDTH:0] load_val, cnt_nxt;

  logic             en_init_n, en_load_n, new_smp_n, out_smp_n;
  logic [WIDTH-1:0] addr_n;

  // INIT walks the counter NREG-1 down to 0, LOAD walks it 0 up to NREG-1.
  ctrl_step_cnt #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_step_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .dir_up   (state == S_LOAD),
    .en       (cnt_en),
    .cnt_nxt  (cnt_nxt),
    .tc       (tc)
  );

  // Arbitration happens in IDLE and on the final step of either phase, so
  // queued work chains on with no idle gap; input samples always win.
  always_comb begin
    state_n    = state;
    launch_smp = 1'b0;
    launch_out = 1'b0;
    load       = 1'b0;
    load_val   = '0;
    cnt_en     = 1'b0;
    if (state == S_IDLE || tc) begin
      load = 1'b1;
      if (pend_smp || smp_valid) begin
        state_n    = S_INIT;
        launch_smp = 1'b1;
        load_val   = LAST;
      end else if (pend_out || out_req) begin
        state_n    = S_LOAD;
        launch_out = 1'b1;
      end else begin
        state_n = S_IDLE;
      end
    end else begin
      cnt_en = 1'b1;
    end
  end

  // In both phases result and error addresses equal the counter value.
  always_comb begin
    en_init_n = 1'b0;
    en_load_n = 1'b0;
    new_smp_n = 1'b0;
    out_smp_n = 1'b0;
    addr_n    = '0;
    case (state_n)
      S_INIT: begin
        en_init_n = 1'b1;
        new_smp_n = (cnt_nxt == '0);
        addr_n    = cnt_nxt[WIDTH-1:0];
      end
      S_LOAD: begin
        en_load_n = 1'b1;
        out_smp_n = (cnt_nxt == LAST);
        addr_n    = cnt_nxt[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  // A launch consumes a set flag; a strobe in that same cycle re-arms it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pend_smp   <= 1'b0;
      pend_out   <= 1'b0;
      overrun    <= 1'b0;
      en_init    <= 1'b0;
      en_load    <= 1'b0;
      new_smp    <= 1'b0;
      out_smp    <= 1'b0;
      result_reg <= '0;
      error_reg  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      pend_smp   <= launch_smp ? (pend_smp & smp_valid) : (pend_smp | smp_valid);
      pend_out   <= launch_out ? (pend_out & out_req) : (pend_out | out_req);
      overrun    <= overrun | (smp_valid & pend_smp & ~launch_smp)
                            | (out_req & pend_out & ~launch_out);
      en_init    <= en_init_n;
      en_load    <= en_load_n;
      new_smp    <= new_smp_n;
      out_smp    <= out_smp_n;
      result_reg <= addr_n;
      error_reg  <= addr_n;
      busy       <= (state_n != S_IDLE);
      done       <= (state == S_LOAD) && tc;
    end
  end

endmodule
